// File: rtl/aes_pkg.sv
// Shared types, constants and byte-level helpers for the iterative AES encryption core.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [AES_BLK_W-1:0] aes_state_t;
    typedef logic [AES_BLK_W-1:0] aes_key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_state_t blk,
    input  aes_key_t   key,
    input  logic       last,
    output aes_state_t result
);

    aes_state_t sub_shift;
    aes_state_t mixed;

    always_comb begin
        // NOTE: defaults first so no path through the block can infer a latch.
        sub_shift = '0;
        mixed     = '0;
        // Byte (row r, column c) sits at bit offset 32*c + 8*r from the MSB.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[AES_BLK_W-1-32*c-8*r -: 8] = sbox(blk[AES_BLK_W-1-32*((c+r)%4)-8*r -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[AES_BLK_W-1-32*c -: 32] = mix_column(sub_shift[AES_BLK_W-1-32*c -: 32]);
        end
    end

    assign result = (last ? sub_shift : mixed) ^ key;

endmodule

// File: rtl/aes_iter.sv
// Iterative AES encryption core, UNROLL rounds per clock, valid/ready on both sides.
// Optional AES_BLK_CNT_EN adds blk_cnt_o, a wrapping count of output handshakes.
module aes_iter
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int UNROLL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [AES_BLK_W-1:0]       plaintext_i,
    input  logic [NR:0][AES_BLK_W-1:0] round_key_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [AES_BLK_W-1:0]       ciphertext_o
`ifdef AES_BLK_CNT_EN
    ,
    output logic [31:0]                blk_cnt_o
`endif
);

    localparam int CNT_W = $clog2(NR + 1);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("aes_iter: UNROLL must be 1 or 2");
    end
    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
        $error("aes_iter: NR must be 10, 12 or 14");
    end

    aes_fsm_t                     fsm_q, fsm_d;
    logic [CNT_W-1:0]             cnt;
    aes_state_t                   state_q;
    logic [UNROLL:0][AES_BLK_W-1:0] stage;
    logic                         accept, out_hs, final_step;

    assign ready_o    = en & ((fsm_q == IDLE) | ((fsm_q == DONE) & ready_i));
    assign accept     = valid_i & ready_o;
    assign out_hs     = valid_o & ready_i;
    assign final_step = (cnt == CNT_W'(NR - UNROLL + 1));

    assign stage[0] = state_q;
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [CNT_W-1:0] rnd;
        assign rnd = cnt + CNT_W'(u);
        aes_round_comb u_round (
            .blk    (stage[u]),
            .key    (round_key_i[rnd]),
            .last   ((u == UNROLL - 1) && (rnd == CNT_W'(NR))),
            .result (stage[u+1])
        );
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = RUN;
            RUN:     if (final_step) fsm_d = DONE;
            DONE:    if (accept) fsm_d = RUN;
                     else if (ready_i) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else if (en) begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            cnt          <= '0;
            valid_o      <= 1'b0;
            ciphertext_o <= '0;
        end else if (en) begin
            if (accept) begin
                state_q <= plaintext_i ^ round_key_i[0];
                cnt     <= CNT_W'(1);
            end else if (fsm_q == RUN) begin
                state_q <= stage[UNROLL];
                cnt     <= final_step ? '0 : cnt + CNT_W'(UNROLL);
            end
            // A handshake in DONE drops valid_o even when a new block is loaded on the same edge.
            if (fsm_q == RUN && final_step) begin
                valid_o      <= 1'b1;
                ciphertext_o <= stage[UNROLL];
            end else if (out_hs) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef AES_BLK_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_o <= '0;
        end else if (en && out_hs) begin
            blk_cnt_o <= blk_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_iter.sv
// Directed known-answer bench for aes_iter: latency, stalls, back-to-back, reset, enable, all NR/UNROLL mixes.
module tb_aes_iter;
    import aes_pkg::*;

    typedef logic [14:0][127:0] rk_all_t;

    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_Z = '0;
    localparam logic [127:0] PT_Z  = '0;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    localparam int X_NR  [5] = '{12, 14, 10, 12, 14};
    localparam int X_U   [5] = '{1, 1, 2, 2, 2};
    localparam int X_LAT [5] = '{13, 15, 6, 7, 8};
    localparam logic [127:0] X_CT [5] = '{
        128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h8ea2b7ca516745bfeafc49904b496089,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089};

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Standard key schedule; the cipher key sits in the MSBs of key.
    function automatic rk_all_t expand_key(input int nr, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rk_all_t     rk;
        int          nk;
        nk   = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        rk = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [255:0] std_key(input int nr);
        logic [255:0] k;
        k = '0;
        for (int i = 0; i < 4*(nr-6); i++) k[255-8*i -: 8] = 8'(i);
        return k;
    endfunction

    logic             clk = 1'b0;
    logic             rst, en, valid_i, ready_i, ready_o, valid_o;
    logic [127:0]     plaintext_i, ciphertext_o;
    logic [10:0][127:0] rk10;
`ifdef AES_BLK_CNT_EN
    logic [31:0]      blk_cnt;
`endif
    logic             valid_x;
    logic             x_vo [5];
    logic [127:0]     x_ct [5];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    aes_iter #(.NR(10), .UNROLL(1)) u_dut (
`ifdef AES_BLK_CNT_EN
        .blk_cnt_o    (blk_cnt),
`endif
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .plaintext_i  (plaintext_i),
        .round_key_i  (rk10),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .ciphertext_o (ciphertext_o)
    );

    for (genvar g = 0; g < 5; g++) begin : g_x
        localparam int N = X_NR[g];
        logic [N:0][127:0] rk;
        rk_all_t           full;
        logic              ro, vo;
        logic [127:0]      ct;
`ifdef AES_BLK_CNT_EN
        logic [31:0]       bc;
`endif
        assign full = expand_key(N, std_key(N));
        assign rk   = full[N:0];
        aes_iter #(.NR(N), .UNROLL(X_U[g])) u_dut (
`ifdef AES_BLK_CNT_EN
            .blk_cnt_o    (bc),
`endif
            .clk          (clk),
            .rst          (rst),
            .en           (1'b1),
            .valid_i      (valid_x),
            .ready_o      (ro),
            .plaintext_i  (PT_A),
            .round_key_i  (rk),
            .valid_o      (vo),
            .ready_i      (1'b1),
            .ciphertext_o (ct)
        );
        assign x_vo[g] = vo;
        assign x_ct[g] = ct;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key10(input logic [255:0] key);
        rk_all_t full;
        full = expand_key(10, key);
        rk10 = full[10:0];
    endtask

    // Caller guarantees ready_o; latency counts edges including the accept edge.
    task automatic run_block(input string tag, input logic [255:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct);
        int n;
        set_key10(key);
        plaintext_i = pt;
        valid_i     = 1'b1;
        tick();
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 11);
        check({tag, "_ct"}, ciphertext_o, exp_ct);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] b_key [4];
        logic [127:0] b_pt  [4];
        logic [127:0] b_ct  [4];
        int           x_lat [5];
        logic [127:0] x_res [5];
        int           n, seen, held, gap;

        rst = 1'b1; en = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        plaintext_i = '0; valid_x = 1'b0;
        set_key10(KEY_A);
        repeat (2) tick();
        check("rst_valid", valid_o, 1'b0);
        check("rst_ct", ciphertext_o, '0);
        check("rst_ready", ready_o, 1'b1);
`ifdef AES_BLK_CNT_EN
        check("rst_blk_cnt", blk_cnt, '0);
`endif
        rst = 1'b0;
        run_block("fips_c1", KEY_A, PT_A, CT_A);
        run_block("fips_b", KEY_B, PT_B, CT_B);
        run_block("zero", KEY_Z, PT_Z, CT_Z);

        // Stall in DONE with valid_i pulses (and junk data) ignored during RUN.
        set_key10(KEY_A);
        plaintext_i = PT_A; valid_i = 1'b1; ready_i = 1'b0;
        tick();
        plaintext_i = ~PT_A;
        n = 1;
        while (!valid_o && n < 40) begin
            valid_i = n[0];
            #1;
            if (n == 4) check("run_ready", ready_o, 1'b0);
            tick();
            n++;
        end
        valid_i = 1'b0;
        check("stall_lat", n, 11);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid_o && ciphertext_o === CT_A && !ready_o) held++;
            tick();
        end
        check("stall_hold", held, 5);
        ready_i = 1'b1;
        #1;
        check("done_ready", ready_o, 1'b1);
        tick();
        check("hs_clear", valid_o, 1'b0);

        // Asynchronous reset around round 5 discards the block.
        set_key10(KEY_A);
        plaintext_i = PT_A; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("arst_ct", ciphertext_o, '0);
        check("arst_ready", ready_o, 1'b1);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (valid_o) seen++;
        end
        check("arst_no_valid", seen, 0);
        run_block("after_rst", KEY_A, PT_A, CT_A);

        // Enable low three cycles mid-RUN, then freeze in DONE.
        set_key10(KEY_B);
        plaintext_i = PT_B; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        n = 7;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        check("en_lat", n, 14);
        check("en_ct", ciphertext_o, CT_B);
        en = 1'b0;
        #1;
        check("en_ready", ready_o, 1'b0);
        tick();
        check("en_hold_valid", valid_o, 1'b1);
        en = 1'b1;
        tick();
        check("en_hs_clear", valid_o, 1'b0);

        // Enable low in IDLE blocks the accept.
        en = 1'b0; valid_i = 1'b1;
        #1;
        check("en_idle_ready", ready_o, 1'b0);
        tick();
        en = 1'b1; valid_i = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (valid_o) seen++;
        end
        check("en_idle_no_run", seen, 0);

        // Back-to-back with valid_i held; key and data change only on accept edges.
        b_key = '{KEY_A, KEY_B, KEY_Z, KEY_A};
        b_pt  = '{PT_A, PT_B, PT_Z, PT_A};
        b_ct  = '{CT_A, CT_B, CT_Z, CT_A};
        valid_i = 1'b1; ready_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            gap = 0;
            while (!ready_o && gap < 40) begin
                tick();
                gap++;
            end
            if (b > 0) begin
                check($sformatf("b2b%0d_gap", b), gap + 1, 11);
                check($sformatf("b2b%0d_ct", b - 1), ciphertext_o, b_ct[b-1]);
            end
            set_key10(b_key[b]);
            plaintext_i = b_pt[b];
            tick();
        end
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        check("b2b3_lat", n, 11);
        check("b2b3_ct", ciphertext_o, b_ct[3]);
        tick();

        // NR 12/14 and UNROLL 2 instances, all started on the same edge.
        for (int g = 0; g < 5; g++) begin
            x_lat[g] = 0;
            x_res[g] = '0;
        end
        valid_x = 1'b1;
        tick();
        valid_x = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            for (int g = 0; g < 5; g++) begin
                if (x_vo[g] && x_lat[g] == 0) begin
                    x_lat[g] = k;
                    x_res[g] = x_ct[g];
                end
            end
            tick();
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("x%0d_lat", g), x_lat[g], X_LAT[g]);
            check($sformatf("x%0d_ct", g), x_res[g], X_CT[g]);
        end

`ifdef AES_BLK_CNT_EN
        force u_dut.blk_cnt_o = 32'hffff_fffe;
        #1;
        release u_dut.blk_cnt_o;
        run_block("cnt0", KEY_A, PT_A, CT_A);
        check("blk_cnt_ffffffff", blk_cnt, 32'hffff_ffff);
        run_block("cnt1", KEY_B, PT_B, CT_B);
        check("blk_cnt_wrap", blk_cnt, 32'h0);
        run_block("cnt2", KEY_Z, PT_Z, CT_Z);
        check("blk_cnt_one", blk_cnt, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
